// File: rtl/ps2_rx_fifo.sv
// PS/2 keyboard receiver: input synchroniser and glitch filter, falling-edge
// strobe, 11-bit frame deframer with parity/stop/timeout checks, and a
// first-word-fall-through FIFO of received scan codes.
//
// Handshake: rd_data is the head entry whenever empty=0; a cycle with
// rd_en=1 and empty=0 pops that entry at the clock edge. rd_en while empty
// is ignored.
module ps2_rx_fifo #(
   parameter int FILTER_LEN  = 8,
   parameter int TIMEOUT_CYC = 100000,
   parameter int FIFO_DEPTH  = 8
) (
   input  logic                              clk,
   input  logic                              rst,
   input  logic                              ps2_clk,
   input  logic                              ps2_data,
   input  logic                              rd_en,
   output logic [7:0]                        rd_data,
   output logic                              empty,
   output logic                              full,
   output logic [$clog2(FIFO_DEPTH+1)-1:0]   count,
   output logic                              frame_err,
   output logic                              overflow
);

   localparam int FW = $clog2(FILTER_LEN + 1);
   localparam int TW = $clog2(TIMEOUT_CYC + 1);
   localparam int AW = $clog2(FIFO_DEPTH);
   localparam int CW = $clog2(FIFO_DEPTH + 1);

   localparam logic [FW-1:0] FILT_LAST = FW'(FILTER_LEN - 1);
   localparam logic [TW-1:0] TO_LAST   = TW'(TIMEOUT_CYC - 1);
   localparam logic [CW-1:0] CNT_FULL  = CW'(FIFO_DEPTH);

   typedef enum logic [1:0] {IDLE, DATA, PARITY, STOP} state_t;

   logic [1:0]    clk_sync_q, dat_sync_q;
   logic          clk_filt_q, dat_filt_q;
   logic [FW-1:0] clk_fcnt_q, dat_fcnt_q;
   logic          clk_prev_q, fall_q;

   state_t        state_q, state_d;
   logic [2:0]    bit_cnt_q, bit_cnt_d;
   logic [7:0]    shift_q, shift_d;
   logic          par_ok_q, par_ok_d;
   logic [TW-1:0] to_cnt_q, to_cnt_d;
   logic          frame_err_q, frame_err_d;
   logic          overflow_q, overflow_d;
   logic          push;

   logic [7:0]    mem_q [FIFO_DEPTH];
   logic [AW-1:0] wr_ptr_q, rd_ptr_q;
   logic [CW-1:0] count_q;
   logic          do_push, do_pop;

   // Two-flop synchronisers; idle bus level is high.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         clk_sync_q <= 2'b11;
         dat_sync_q <= 2'b11;
      end else begin
         clk_sync_q <= {clk_sync_q[0], ps2_clk};
         dat_sync_q <= {dat_sync_q[0], ps2_data};
      end
   end

   // Filtered levels flip only after FILTER_LEN consecutive differing samples.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         clk_filt_q <= 1'b1;
         clk_fcnt_q <= '0;
         dat_filt_q <= 1'b1;
         dat_fcnt_q <= '0;
      end else begin
         if (clk_sync_q[1] == clk_filt_q) begin
            clk_fcnt_q <= '0;
         end else if (clk_fcnt_q == FILT_LAST) begin
            clk_filt_q <= clk_sync_q[1];
            clk_fcnt_q <= '0;
         end else begin
            clk_fcnt_q <= clk_fcnt_q + 1'b1;
         end
         if (dat_sync_q[1] == dat_filt_q) begin
            dat_fcnt_q <= '0;
         end else if (dat_fcnt_q == FILT_LAST) begin
            dat_filt_q <= dat_sync_q[1];
            dat_fcnt_q <= '0;
         end else begin
            dat_fcnt_q <= dat_fcnt_q + 1'b1;
         end
      end
   end

   // One-cycle strobe on each falling edge of the filtered PS/2 clock.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         clk_prev_q <= 1'b1;
         fall_q     <= 1'b0;
      end else begin
         clk_prev_q <= clk_filt_q;
         fall_q     <= clk_prev_q & ~clk_filt_q;
      end
   end

   // Deframer state and registered error pulses.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q     <= IDLE;
         bit_cnt_q   <= '0;
         shift_q     <= '0;
         par_ok_q    <= 1'b0;
         to_cnt_q    <= '0;
         frame_err_q <= 1'b0;
         overflow_q  <= 1'b0;
      end else begin
         state_q     <= state_d;
         bit_cnt_q   <= bit_cnt_d;
         shift_q     <= shift_d;
         par_ok_q    <= par_ok_d;
         to_cnt_q    <= to_cnt_d;
         frame_err_q <= frame_err_d;
         overflow_q  <= overflow_d;
      end
   end

   // Next-state logic: advances on strobes; the timeout counts idle cycles
   // from the edge that consumed the last strobe and aborts the frame.
   always_comb begin
      state_d     = state_q;
      bit_cnt_d   = bit_cnt_q;
      shift_d     = shift_q;
      par_ok_d    = par_ok_q;
      to_cnt_d    = '0;
      frame_err_d = 1'b0;
      push        = 1'b0;
      if (state_q != IDLE && !fall_q) begin
         to_cnt_d = to_cnt_q + 1'b1;
      end
      if (state_q != IDLE && !fall_q && to_cnt_q == TO_LAST) begin
         state_d     = IDLE;
         frame_err_d = 1'b1;
         to_cnt_d    = '0;
      end else if (fall_q) begin
         case (state_q)
            IDLE: begin
               if (!dat_filt_q) begin
                  state_d   = DATA;
                  bit_cnt_d = '0;
                  shift_d   = '0;
               end
            end
            DATA: begin
               shift_d   = {dat_filt_q, shift_q[7:1]};
               bit_cnt_d = bit_cnt_q + 1'b1;
               if (bit_cnt_q == 3'd7) state_d = PARITY;
            end
            PARITY: begin
               par_ok_d = (^shift_q) ^ dat_filt_q;
               state_d  = STOP;
            end
            STOP: begin
               state_d = IDLE;
               if (dat_filt_q && par_ok_q) push = 1'b1;
               else frame_err_d = 1'b1;
            end
            default: state_d = IDLE;
         endcase
      end
   end

   // A good byte arriving while full is dropped unless a pop frees a slot.
   assign do_pop     = rd_en & ~empty;
   assign do_push    = push & (~full | do_pop);
   assign overflow_d = push & full & ~rd_en;

   // FIFO storage, wrapping pointers and occupancy count.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         for (int i = 0; i < FIFO_DEPTH; i++) mem_q[i] <= '0;
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         count_q  <= '0;
      end else begin
         if (do_push) begin
            mem_q[wr_ptr_q] <= shift_q;
            wr_ptr_q        <= wr_ptr_q + 1'b1;
         end
         if (do_pop) rd_ptr_q <= rd_ptr_q + 1'b1;
         case ({do_push, do_pop})
            2'b10:   count_q <= count_q + 1'b1;
            2'b01:   count_q <= count_q - 1'b1;
            default: count_q <= count_q;
         endcase
      end
   end

   assign rd_data   = mem_q[rd_ptr_q];
   assign empty     = (count_q == '0);
   assign full      = (count_q == CNT_FULL);
   assign count     = count_q;
   assign frame_err = frame_err_q;
   assign overflow  = overflow_q;

endmodule
